mem_read_port: RTL
==================

Name: mem_read_port

Overview:
Read-side sequencer between the CPU control FSM and the synchronous data/instruction RAM. It accepts a single read request and drives the RAM address and read strobe. It waits a fixed RAM read latency, then captures the returned word into a holding register. It presents that word with a valid/ack handshake until the consumer takes it. This is the consumer-side counterpart of the load-enabled register writes in the datapath.

Parameters:
k, 16, data word width
n, 8, address width
LAT, 1, RAM read latency in clock edges after the edge that samples mem_addr; legal range 1..4

Ports:
clock  input  1  sole clock, rising-edge
reset_n  input  1  asynchronous, active-low reset
req  input  1  read request, sampled only in IDLE or on the acking edge in HOLD
addr  input  n  read address, sampled with req
ack  input  1  consumer accepts dout; meaningful only while valid=1
busy  output  1  high whenever state is not IDLE
valid  output  1  dout holds a captured word not yet acked
dout  output  k  captured read data, stable while valid=1
mem_addr  output  n  registered address to RAM
mem_read  output  1  one-cycle read strobe to RAM
mem_rdata  input  k  RAM read data

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, valid=0, busy=0, mem_read=0, mem_addr=0, dout=0, counter=0. Release takes effect on the next rising edge.
- Reset mid-operation abandons the transaction. No capture occurs and no valid pulse follows release.
- States are IDLE, ISSUE, WAIT, HOLD. All outputs are registered.
- IDLE: on an edge with req=1, set mem_addr<=addr, mem_read<=1, and state<=ISSUE.
- IDLE with req=0: mem_read and mem_addr hold their values (mem_read=0).
- ISSUE (one cycle; RAM samples mem_addr on the next edge):
  - on that edge, mem_read<=0 and counter<=LAT-1;
  - if LAT=1, state<=HOLD and dout<=mem_rdata is NOT done here; go to WAIT with counter=0.
- WAIT: each edge decrements the counter. On the edge where counter==0, dout<=mem_rdata, valid<=1, and state<=HOLD.
- Latency: with req sampled at edge E0, valid rises after edge E(1+LAT). For LAT=1, valid is high after E2.
- HOLD, ack=0: dout and valid hold indefinitely.
- HOLD, ack=1, req=0: valid<=0 and state<=IDLE.
- HOLD, ack=1, req=1 (simultaneous): the back-to-back read is accepted. valid<=0, mem_addr<=addr, mem_read<=1, state<=ISSUE. No idle bubble.
- req while busy (ISSUE/WAIT, or HOLD without ack) is ignored and not queued. Changes to addr are also ignored in those states.
- ack while valid=0 is ignored.
- dout changes only on a capture edge; it keeps its last value after ack, until the next capture.
- busy = (state != IDLE) and is registered from the next state.
- Width rules:
  - counter width is clog2(LAT+1), minimum 1;
  - no arithmetic on data; addr and dout pass through unmodified.
- LAT outside 1..4 is a configuration error and is flagged by an elaboration-time check.

Decomposition:
- Shared package: state encodings (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, HOLD=2'd3) and the legal LAT bounds. These are shared with the CPU FSM for busy/valid decoding.
- One natural sub-module, rd_hold_reg: a k-bit load-enabled register with asynchronous active-low clear.
  - Instantiate it for dout (load = capture edge).
  - Instantiate it for mem_addr (load = accept edge).
- The FSM and counter stay in mem_read_port.

Test Plan:
- Reset then idle: hold reset_n=0 for 3 cycles and release, with no req for 5 cycles. Required: valid=0, busy=0, mem_read=0, mem_addr=0, dout=0 throughout.
- Single read, LAT=1: req=1 with addr=8'h12 at E0; RAM model returns 16'hBEEF. Required:
  - mem_read=1 only in the cycle after E0, with mem_addr=8'h12;
  - valid=1 and dout=16'hBEEF after E2;
  - valid stays high until ack;
  - ack at E5 drops valid after E5, busy=0 after E5, and dout remains 16'hBEEF.
- Back-to-back reads: in HOLD holding 16'hBEEF, assert ack=1, req=1, addr=8'h34 (RAM returns 16'h1234) on one edge. Required: no IDLE cycle, mem_read=1 the next cycle with mem_addr=8'h34, and valid rises again two edges later with dout=16'h1234.
- Busy rejection: during WAIT, pulse req with addr=8'h55. Required: mem_addr and mem_read unchanged, exactly one valid for the original address, no second transaction.
- LAT=3 instance: req at E0 with addr=8'h07 (RAM returns 16'h00A5). Required: valid=1 after E4 and not before, dout=16'h00A5.
- Reset mid-WAIT: assert reset_n=0 asynchronously between edges during WAIT. Required: outputs clear immediately without waiting for an edge, and after release there is no valid pulse within 6 cycles.

Source files
------------

// File: rtl/mem_read_port_pkg.sv
// Shared definitions for the RAM read sequencer: state encoding (also decoded by the
// CPU control FSM for busy/valid) and the supported read-latency range.
package mem_read_port_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_HOLD  = 2'd3
   } rd_state_e;

   localparam int LAT_MIN = 1;
   localparam int LAT_MAX = 4;

   // Latency counter must hold values 0..LAT-1; never narrower than one bit.
   function automatic int cnt_width(input int lat);
      int w;
      w = $clog2(lat + 1);
      return (w < 1) ? 1 : w;
   endfunction

   function automatic bit lat_legal(input int lat);
      return (lat >= LAT_MIN) && (lat <= LAT_MAX);
   endfunction

endpackage

// File: rtl/mem_read_port_if.sv
// Bundle of the consumer handshake (req/addr/ack -> busy/valid/dout) and the RAM
// read bus (mem_addr/mem_read -> mem_rdata) seen by the read sequencer.
interface mem_read_port_if #(
   parameter int k = 16,
   parameter int n = 8
);
   logic         req;
   logic [n-1:0] addr;
   logic         ack;
   logic         busy;
   logic         valid;
   logic [k-1:0] dout;
   logic [n-1:0] mem_addr;
   logic         mem_read;
   logic [k-1:0] mem_rdata;

   // The sequencer itself.
   modport slave (
      input  req, addr, ack, mem_rdata,
      output busy, valid, dout, mem_addr, mem_read
   );

   // Everything around it: the requesting FSM and the RAM.
   modport master (
      output req, addr, ack, mem_rdata,
      input  busy, valid, dout, mem_addr, mem_read
   );
endinterface

// File: rtl/mem_read_port_rd_hold_reg.sv
// W-bit load-enabled holding register with asynchronous active-low clear; holds its
// value on every edge where load_i is low.
module rd_hold_reg #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] data_q;
   logic [W-1:0] data_d;

   assign data_d = load_i ? d_i : data_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign q_o = data_q;

endmodule

// File: rtl/mem_read_port.sv
// Read-side sequencer: accepts one read, strobes the RAM, waits LAT edges, captures the
// returned word and holds it under a valid/ack handshake. All outputs are registered.
module mem_read_port
   import mem_read_port_pkg::*;
#(
   parameter int k   = 16,
   parameter int n   = 8,
   parameter int LAT = 1
) (
   input  logic             clock,
   input  logic             reset_n,
   mem_read_port_if.slave   bus
);

   localparam int CW = cnt_width(LAT);

   if (!lat_legal(LAT)) begin : g_lat_check
      $error("mem_read_port: LAT=%0d is outside the supported range %0d..%0d",
             LAT, LAT_MIN, LAT_MAX);
   end

   rd_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          valid_q, valid_d;
   logic          busy_q;
   logic          mem_read_q, mem_read_d;
   logic          addr_load;
   logic          cap_load;
   logic [n-1:0]  mem_addr_q;
   logic [k-1:0]  dout_q;

   // Next-state, counter and load enables. A request is only looked at in IDLE or on
   // the acking edge in HOLD; in HOLD that makes back-to-back reads bubble-free.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      valid_d    = valid_q;
      mem_read_d = 1'b0;
      addr_load  = 1'b0;
      cap_load   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.req) begin
               addr_load  = 1'b1;
               mem_read_d = 1'b1;
               state_d    = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            cnt_d   = CW'(LAT - 1);
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               cap_load = 1'b1;
               valid_d  = 1'b1;
               state_d  = ST_HOLD;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_HOLD: begin
            if (bus.ack) begin
               valid_d = 1'b0;
               if (bus.req) begin
                  addr_load  = 1'b1;
                  mem_read_d = 1'b1;
                  state_d    = ST_ISSUE;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         mem_read_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         valid_q    <= valid_d;
         busy_q     <= (state_d != ST_IDLE);
         mem_read_q <= mem_read_d;
      end
   end

   rd_hold_reg #(.W(n)) u_addr_reg (
      .clk_i  (clock),
      .rst_ni (reset_n),
      .load_i (addr_load),
      .d_i    (bus.addr),
      .q_o    (mem_addr_q)
   );

   rd_hold_reg #(.W(k)) u_dout_reg (
      .clk_i  (clock),
      .rst_ni (reset_n),
      .load_i (cap_load),
      .d_i    (bus.mem_rdata),
      .q_o    (dout_q)
   );

   assign bus.busy     = busy_q;
   assign bus.valid    = valid_q;
   assign bus.dout     = dout_q;
   assign bus.mem_addr = mem_addr_q;
   assign bus.mem_read = mem_read_q;

endmodule
